bmux_arb: RTL and testbench

BMUX_ARB -- requirements
Module: bmux_arb

---
 rtl/bmux_pkg.sv | 17 +
 rtl/bmux_arb_rr_pick.sv | 28 ++
 rtl/bmux_arb.sv | 103 ++++++++++
 tb/tb_bmux_arb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bmux_pkg.sv
// Shared constants and helpers for the bmux_arb selector.
package bmux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Index width for n items, never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bmux_arb_rr_pick.sv
// Rotated-priority picker: first requester at or after ptr wins.
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  int j;

  // Scan from the far end so the closest hit to ptr is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'(j);
      end
    end
  end

endmodule

// File: rtl/bmux_arb.sv
// N-way registered selector: direct select or round-robin,
// with a one-word valid/ready output register.
module bmux_arb
  import bmux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  localparam int SELW = clog2(N)
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SELW-1:0]  s,
  input  logic [N*WIDTH-1:0] A,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [WIDTH-1:0] r,
  output logic             r_valid,
  output logic [SELW-1:0]  r_src,
  input  logic             r_ready
);

  logic [WIDTH-1:0] r_q, r_d;
  logic             r_valid_q, r_valid_d;
  logic [SELW-1:0]  src_q, src_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic            load_ok;
  logic            dir_v, rr_v, gnt_v, xfer;
  logic [SELW-1:0] rr_idx, gnt_idx;

  assign load_ok = !r_valid_q || r_ready;

  // Out-of-range selects never match any channel.
  always_comb begin
    dir_v = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (s == SELW'(i)) dir_v = in_valid[i];
    end
  end

  rr_pick #(
    .N   (N),
    .SELW(SELW)
  ) u_pick (
    .req      (in_valid),
    .ptr      (ptr_q),
    .gnt_valid(rr_v),
    .gnt_idx  (rr_idx)
  );

  always_comb begin
    gnt_v   = dir_v;
    gnt_idx = s;
    if (mode == MODE_RR) begin
      gnt_v   = rr_v;
      gnt_idx = rr_idx;
    end
  end

  assign xfer = rst_n && load_ok && gnt_v;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    r_d       = r_q;
    r_valid_d = r_valid_q;
    src_d     = src_q;
    ptr_d     = ptr_q;
    if (xfer) begin
      r_d       = A[int'(gnt_idx)*WIDTH +: WIDTH];
      src_d     = gnt_idx;
      r_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (r_ready) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= '0;
      r_valid_q <= 1'b0;
      src_q     <= '0;
      ptr_q     <= '0;
    end else begin
      r_q       <= r_d;
      r_valid_q <= r_valid_d;
      src_q     <= src_d;
      ptr_q     <= ptr_d;
    end
  end

  assign r       = r_q;
  assign r_valid = r_valid_q;
  assign r_src   = src_q;

endmodule

// File: tb/tb_bmux_arb.sv
// Directed bench for bmux_arb: N=4 main instance plus N=3 range check.
module tb_bmux_arb;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;

  logic        mode = 1'b0;
  logic [1:0]  s = '0;
  logic [63:0] A = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [15:0] r;
  logic        r_valid;
  logic [1:0]  r_src;
  logic        r_ready = 1'b0;

  logic        mode3 = 1'b0;
  logic [1:0]  s3 = '0;
  logic [47:0] A3 = '0;
  logic [2:0]  in_valid3 = '0;
  logic [2:0]  in_ready3;
  logic [15:0] r3;
  logic        r_valid3;
  logic [1:0]  r_src3;
  logic        r_ready3 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bmux_arb #(.WIDTH(16), .N(4)) dut (
    .CLK(CLK), .rst_n(rst_n), .mode(mode), .s(s), .A(A),
    .in_valid(in_valid), .in_ready(in_ready), .r(r),
    .r_valid(r_valid), .r_src(r_src), .r_ready(r_ready)
  );

  bmux_arb #(.WIDTH(16), .N(3)) dut3 (
    .CLK(CLK), .rst_n(rst_n), .mode(mode3), .s(s3), .A(A3),
    .in_valid(in_valid3), .in_ready(in_ready3), .r(r3),
    .r_valid(r_valid3), .r_src(r_src3), .r_ready(r_ready3)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mode = 1'b0;
    s = 2'd2;
    in_valid = 4'b0100;
    A[2*16 +: 16] = 16'h0003;
    r_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (r !== 16'h0) begin errors++; $display("FAIL rst_r: got %h want 0000", r); end
    checks++;
    if (r_valid !== 1'b0) begin errors++; $display("FAIL rst_rv: got %b want 0", r_valid); end
    checks++;
    if (in_ready !== 4'b0) begin errors++; $display("FAIL rst_rdy: got %b want 0000", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin errors++; $display("FAIL dir_rdy: got %b want 0100", in_ready); end
    tick();
    checks++;
    if (r !== 16'h0003) begin errors++; $display("FAIL dir_r: got %h want 0003", r); end
    checks++;
    if (r_valid !== 1'b1) begin errors++; $display("FAIL dir_rv: got %b want 1", r_valid); end
    checks++;
    if (r_src !== 2'd2) begin errors++; $display("FAIL dir_src: got %0d want 2", r_src); end
  endtask

  task automatic test_backpressure();
    r_ready = 1'b0;
    s = 2'd1;
    in_valid = 4'b0010;
    A[1*16 +: 16] = 16'h0055;
    #1;
    checks++;
    if (in_ready !== 4'b0) begin errors++; $display("FAIL bp_rdy0: got %b want 0000", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (r !== 16'h0003 || r_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got r=%h v=%b want r=0003 v=1", k, r, r_valid);
      end
      checks++;
      if (in_ready !== 4'b0) begin errors++; $display("FAIL bp_rdy%0d: got %b want 0000", k, in_ready); end
    end
    r_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_go: got %b want 0010", in_ready); end
    tick();
    checks++;
    if (r !== 16'h0055 || r_src !== 2'd1 || r_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_new: got r=%h src=%0d v=%b want 0055/1/1", r, r_src, r_valid);
    end
    in_valid = 4'b0;
    tick();
    checks++;
    if (r_valid !== 1'b0 || r !== 16'h0055 || r_src !== 2'd1) begin
      errors++;
      $display("FAIL drain: got r=%h src=%0d v=%b want 0055/1/0", r, r_src, r_valid);
    end
    checks++;
    if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL dir_ptr: got %0d want 0", dut.ptr_q); end
  endtask

  task automatic test_rr_fair();
    mode = 1'b1;
    in_valid = 4'b1111;
    A = {16'd4, 16'd3, 16'd2, 16'd1};
    r_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (r !== 16'((k % 4) + 1) || r_src !== 2'(k % 4) || r_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr%0d: got r=%h src=%0d v=%b want %0d/%0d/1", k, r, r_src, r_valid, (k % 4) + 1, k % 4);
      end
    end
    in_valid = 4'b0;
    checks++;
    if (dut.ptr_q !== 2'd1) begin errors++; $display("FAIL rr_ptr: got %0d want 1", dut.ptr_q); end
  endtask

  task automatic test_rr_wrap();
    in_valid = 4'b0100;
    tick();
    checks++;
    if (r_src !== 2'd2 || dut.ptr_q !== 2'd3) begin
      errors++;
      $display("FAIL wrap_set: got src=%0d ptr=%0d want 2/3", r_src, dut.ptr_q);
    end
    in_valid = 4'b0011;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin errors++; $display("FAIL wrap_rdy: got %b want 0001", in_ready); end
    tick();
    checks++;
    if (r !== 16'd1 || r_src !== 2'd0 || dut.ptr_q !== 2'd1) begin
      errors++;
      $display("FAIL wrap_ch0: got r=%h src=%0d ptr=%0d want 1/0/1", r, r_src, dut.ptr_q);
    end
    in_valid = 4'b0010;
    tick();
    checks++;
    if (r !== 16'd2 || r_src !== 2'd1 || dut.ptr_q !== 2'd2) begin
      errors++;
      $display("FAIL wrap_ch1: got r=%h src=%0d ptr=%0d want 2/1/2", r, r_src, dut.ptr_q);
    end
    in_valid = 4'b0;
    tick();
    checks++;
    if (r_valid !== 1'b0 || dut.ptr_q !== 2'd2) begin
      errors++;
      $display("FAIL wrap_idle: got v=%b ptr=%0d want 0/2", r_valid, dut.ptr_q);
    end
  endtask

  task automatic test_out_of_range();
    mode3 = 1'b0;
    s3 = 2'd3;
    in_valid3 = 3'b111;
    A3 = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    r_ready3 = 1'b1;
    #1;
    checks++;
    if (in_ready3 !== 3'b000) begin errors++; $display("FAIL oor_rdy: got %b want 000", in_ready3); end
    tick();
    tick();
    checks++;
    if (r_valid3 !== 1'b0) begin errors++; $display("FAIL oor_rv: got %b want 0", r_valid3); end
    s3 = 2'd1;
    #1;
    checks++;
    if (in_ready3 !== 3'b010) begin errors++; $display("FAIL n3_rdy: got %b want 010", in_ready3); end
    tick();
    checks++;
    if (r3 !== 16'hBBBB || r_src3 !== 2'd1 || r_valid3 !== 1'b1) begin
      errors++;
      $display("FAIL n3_xfer: got r=%h src=%0d v=%b want BBBB/1/1", r3, r_src3, r_valid3);
    end
    in_valid3 = 3'b000;
  endtask

  task automatic test_async_reset();
    mode = 1'b0;
    s = 2'd0;
    in_valid = 4'b0001;
    A[0 +: 16] = 16'h1234;
    r_ready = 1'b0;
    tick();
    in_valid = 4'b0;
    checks++;
    if (r !== 16'h1234 || r_valid !== 1'b1 || r_src !== 2'd0) begin
      errors++;
      $display("FAIL ar_load: got r=%h v=%b src=%0d want 1234/1/0", r, r_valid, r_src);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (r !== 16'h0 || r_valid !== 1'b0 || r_src !== 2'd0) begin
      errors++;
      $display("FAIL ar_clr: got r=%h v=%b src=%0d want 0/0/0", r, r_valid, r_src);
    end
    checks++;
    if (dut.ptr_q !== 2'd0 || in_ready !== 4'b0) begin
      errors++;
      $display("FAIL ar_ptr: got ptr=%0d rdy=%b want 0/0000", dut.ptr_q, in_ready);
    end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_rr_fair();
    test_rr_wrap();
    test_out_of_range();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
